code_conv_pipe: RTL and testbench

Parametrised, pipelined multi-digit code converter for the universal code converter. Each cycle it accepts one word of `DIGITS` 4-bit digits in a selectable source code (binary, BCD, excess-3, Gray) and returns it in a selectable destination code. Every digit carries its own error flag, and a saturating counter records words that contained errors. It sits between the input capture logic and the display/output stage, and replaces the fixed single-digit combinational converters with one streaming block.

---
 rtl/code_conv_pkg.sv | 15 +
 rtl/code_digit_conv.sv | 57 +++++
 rtl/code_conv_pipe.sv | 91 +++++++++
 tb/tb_code_conv_pipe.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/code_conv_pkg.sv
// Shared code definitions for the multi-digit code converter pipeline.
package code_conv_pkg;

  typedef enum logic [1:0] {
    BIN  = 2'd0,
    BCD  = 2'd1,
    EX3  = 2'd2,
    GRAY = 2'd3
  } code_t;

  localparam int unsigned DIGIT_W    = 4;
  localparam logic [3:0]  BCD_MAX    = 4'd9;
  localparam logic [3:0]  EX3_OFFSET = 4'd3;

endpackage

// File: rtl/code_digit_conv.sv
// Single-digit combinational converter: decodes into a plain value (ENCODE=0)
// or encodes a plain value into the destination code (ENCODE=1).
module code_digit_conv
  import code_conv_pkg::*;
#(
  parameter bit ENCODE = 1'b0
) (
  input  logic [DIGIT_W-1:0] din,
  input  code_t              code,
  output logic [DIGIT_W-1:0] dout,
  output logic               err
);

  // Returns {err, value}.
  function automatic logic [DIGIT_W:0] decode(input logic [DIGIT_W-1:0] d, input code_t src);
    logic [DIGIT_W-1:0] v;
    logic               e;
    v = d;
    e = 1'b0;
    case (src)
      BCD:  e = (d > BCD_MAX);
      EX3: begin
        e = (d < EX3_OFFSET) || (d > (BCD_MAX + EX3_OFFSET));
        v = d - EX3_OFFSET;
      end
      GRAY: begin
        for (int unsigned i = 0; i < DIGIT_W - 1; i++)
          v[DIGIT_W-2-i] = v[DIGIT_W-1-i] ^ d[DIGIT_W-2-i];
      end
      default: ;
    endcase
    return {e, v};
  endfunction

  function automatic logic [DIGIT_W:0] encode(input logic [DIGIT_W-1:0] v, input code_t dst);
    logic [DIGIT_W-1:0] d;
    logic               e;
    d = v;
    e = 1'b0;
    case (dst)
      BCD:  e = (v > BCD_MAX);
      EX3: begin
        e = (v > BCD_MAX);
        d = v + EX3_OFFSET;
      end
      GRAY: d = v ^ (v >> 1);
      default: ;
    endcase
    return {e, d};
  endfunction

  always_comb begin
    if (ENCODE) {err, dout} = encode(din, code);
    else        {err, dout} = decode(din, code);
  end

endmodule

// File: rtl/code_conv_pipe.sv
// Two-stage streaming code converter: S1 holds decoded values, S2 drives the
// encoded outputs; a saturating counter tallies transferred words with errors.
module code_conv_pipe
  import code_conv_pkg::*;
#(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4*DIGITS-1:0]      in_data,
  input  logic [1:0]               in_src,
  input  logic [1:0]               in_dst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [4*DIGITS-1:0]      out_data,
  output logic [DIGITS-1:0]        out_err,
  output logic [ERR_CNT_W-1:0]     err_count,
  input  logic                     clr_err
);

  localparam int unsigned W = DIGIT_W * DIGITS;

  logic              s1_valid;
  logic [W-1:0]      s1_v;
  logic [DIGITS-1:0] s1_derr;
  code_t             s1_dst;

  logic [W-1:0]      dec_v, enc_d, s2_d;
  logic [DIGITS-1:0] dec_err, enc_err, s2_e;
  logic              s1_load, s2_load, in_xfer;

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = !rst && s1_load;
  assign in_xfer  = in_valid && in_ready;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    code_digit_conv #(.ENCODE(1'b0)) u_dec (
      .din  (in_data[k*DIGIT_W +: DIGIT_W]),
      .code (code_t'(in_src)),
      .dout (dec_v[k*DIGIT_W +: DIGIT_W]),
      .err  (dec_err[k])
    );
    code_digit_conv #(.ENCODE(1'b1)) u_enc (
      .din  (s1_v[k*DIGIT_W +: DIGIT_W]),
      .code (s1_dst),
      .dout (enc_d[k*DIGIT_W +: DIGIT_W]),
      .err  (enc_err[k])
    );
    assign s2_d[k*DIGIT_W +: DIGIT_W] = s2_e[k] ? '0 : enc_d[k*DIGIT_W +: DIGIT_W];
  end

  assign s2_e = s1_derr | enc_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_v      <= '0;
      s1_derr   <= '0;
      s1_dst    <= BIN;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= '0;
    end else begin
      if (s1_load) s1_valid <= in_xfer;
      if (in_xfer) begin
        s1_v    <= dec_v;
        s1_derr <= dec_err;
        s1_dst  <= code_t'(in_dst);
      end
      if (s2_load) out_valid <= s1_valid;
      // Output registers only change when a real word moves in, so a stalled
      // or emptied stage keeps its last contents stable.
      if (s2_load && s1_valid) begin
        out_data <= s2_d;
        out_err  <= s2_e;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_err)
      err_count <= '0;
    else if (out_valid && out_ready && (|out_err) && (err_count != '1))
      err_count <= err_count + 1'b1;
  end

endmodule

// File: tb/tb_code_conv_pipe.sv
// Directed and randomised checks of code_conv_pipe at DIGITS = 4, 1 and 6.
module tb_code_conv_pipe;

  logic        clk = 1'b0;
  logic        rst;
  int          tests = 0;
  int          fails = 0;
  logic [7:0]  exp_cnt;

  always #5 clk = ~clk;

  // DIGITS = 4 instance
  logic        in_valid, in_ready, out_valid, out_ready, clr_err;
  logic [15:0] in_data, out_data;
  logic [1:0]  in_src, in_dst;
  logic [3:0]  out_err;
  logic [7:0]  err_count;

  code_conv_pipe #(.DIGITS(4), .ERR_CNT_W(8)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_src(in_src), .in_dst(in_dst),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .err_count(err_count), .clr_err(clr_err)
  );

  // DIGITS = 1 instance
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_clr_err;
  logic [3:0]  a_in_data, a_out_data;
  logic [1:0]  a_in_src, a_in_dst;
  logic [0:0]  a_out_err;
  logic [7:0]  a_err_count;

  code_conv_pipe #(.DIGITS(1), .ERR_CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_src(a_in_src), .in_dst(a_in_dst),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_err(a_out_err), .err_count(a_err_count), .clr_err(a_clr_err)
  );

  // DIGITS = 6 instance
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_clr_err;
  logic [23:0] b_in_data, b_out_data;
  logic [1:0]  b_in_src, b_in_dst;
  logic [5:0]  b_out_err;
  logic [7:0]  b_err_count;

  code_conv_pipe #(.DIGITS(6), .ERR_CNT_W(8)) dut6 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_src(b_in_src), .in_dst(b_in_dst),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_err(b_out_err), .err_count(b_err_count), .clr_err(b_clr_err)
  );

  typedef struct packed {
    logic [23:0] d;
    logic [5:0]  e;
  } word_t;

  word_t qa[$];
  word_t qb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: gray decode by searching for the value whose gray code matches.
  function automatic logic [4:0] ref_digit(input logic [3:0] d, input logic [1:0] s, input logic [1:0] t);
    logic [3:0] v;
    logic       bad;
    v   = d;
    bad = 1'b0;
    case (s)
      2'd1: bad = (d > 4'd9);
      2'd2: begin bad = (d < 4'd3) || (d > 4'd12); v = d - 4'd3; end
      2'd3: for (int unsigned g = 0; g < 16; g++)
              if ((4'(g) ^ (4'(g) >> 1)) == d) v = 4'(g);
      default: ;
    endcase
    case (t)
      2'd1: if (v > 4'd9) bad = 1'b1;
      2'd2: begin if (v > 4'd9) bad = 1'b1; v = v + 4'd3; end
      2'd3: v = v ^ (v >> 1);
      default: ;
    endcase
    return bad ? 5'b10000 : {1'b0, v};
  endfunction

  function automatic word_t ref_word(input int n, input logic [23:0] data, input logic [1:0] s, input logic [1:0] t);
    word_t      w;
    logic [4:0] r;
    w = '0;
    for (int k = 0; k < n; k++) begin
      r = ref_digit(data[4*k +: 4], s, t);
      w.d[4*k +: 4] = r[3:0];
      w.e[k]        = r[4];
    end
    return w;
  endfunction

  // Entered and left at 1 time unit after a rising edge, out_ready held high.
  task automatic send_one(input string tag, input logic [1:0] s, input logic [1:0] t,
                          input logic [15:0] data, input logic [15:0] xd, input logic [3:0] xe);
    in_valid = 1'b1; in_src = s; in_dst = t; in_data = data;
    @(negedge clk);
    check({tag, " in_ready"}, in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_src = ~s; in_dst = ~t; in_data = ~data;
    @(posedge clk); #1;
    check({tag, " out_valid"}, out_valid, 1'b1);
    check({tag, " out_data"}, out_data, xd);
    check({tag, " out_err"}, out_err, xe);
    @(posedge clk); #1;
    if (xe != 4'd0 && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
    check({tag, " err_count"}, err_count, exp_cnt);
    check({tag, " drained"}, out_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] wv [4];
    int          idx, got;
    logic        acc, a_acc, b_acc;
    word_t       e;

    rst = 1'b1; clr_err = 1'b0; in_valid = 1'b0; in_data = '0;
    in_src = 2'd0; in_dst = 2'd0; out_ready = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_in_src = '0; a_in_dst = '0; a_out_ready = 1'b1; a_clr_err = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_in_src = '0; b_in_dst = '0; b_out_ready = 1'b1; b_clr_err = 1'b0;
    exp_cnt = 8'd0;

    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", in_ready, 1'b0);
    check("reset out_valid", out_valid, 1'b0);
    check("reset out_data", out_data, 16'h0000);
    check("reset out_err", out_err, 4'b0000);
    check("reset err_count", err_count, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    check("post-reset in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Hand-derived vectors: {src, dst, in, out, err}
    send_one("ex3->gray", 2'd2, 2'd3, 16'h3C45, 16'h0D13, 4'b0000);
    send_one("bcd->ex3",  2'd1, 2'd2, 16'h1297, 16'h45CA, 4'b0000);
    send_one("bcd->bin",  2'd1, 2'd0, 16'hA5F3, 16'h0503, 4'b1010);
    send_one("ex3->bcd",  2'd2, 2'd1, 16'h2D3C, 16'h0009, 4'b1100);
    send_one("bin->bcd",  2'd0, 2'd1, 16'h9A0F, 16'h9000, 4'b0101);
    send_one("gray->bin", 2'd3, 2'd0, 16'h8F31, 16'hFA21, 4'b0000);
    send_one("bin->ex3",  2'd0, 2'd2, 16'h0A69, 16'h309C, 4'b0100);
    send_one("bin->gray", 2'd0, 2'd3, 16'h7F05, 16'h4807, 4'b0000);
    send_one("bcd->bcd",  2'd1, 2'd1, 16'h0F9B, 16'h0090, 4'b0101);

    // Stall: four words, output blocked for three cycles after the pipe fills.
    wv[0] = 16'h1111; wv[1] = 16'h2222; wv[2] = 16'h3333; wv[3] = 16'h4444;
    idx = 0; got = 0;
    in_src = 2'd0; in_dst = 2'd0;
    for (int c = 0; c < 20; c++) begin
      if (idx < 4) begin in_valid = 1'b1; in_data = wv[idx]; end
      else         begin in_valid = 1'b0; in_data = '0; end
      out_ready = (c >= 5);
      @(negedge clk);
      if (c >= 2 && c <= 4) begin
        check("stall in_ready", in_ready, 1'b0);
        check("stall out_valid", out_valid, 1'b1);
        check("stall out_data", out_data, 16'h1111);
      end
      if (out_valid && out_ready) begin
        check("stall order", out_data, (got < 4) ? wv[got] : 16'hxxxx);
        got++;
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    check("stall words out", got, 4);
    out_ready = 1'b1; in_valid = 1'b0;

    // Reset with two errored words in flight.
    in_src = 2'd1; in_dst = 2'd1; in_data = 16'hFFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("midreset in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; exp_cnt = 8'd0;
    check("midreset out_valid", out_valid, 1'b0);
    check("midreset err_count", err_count, 8'h00);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("midreset no stale", out_valid, 1'b0);
    end
    check("midreset count stays", err_count, 8'h00);

    // Saturation: 256 errored words.
    in_valid = 1'b1;
    repeat (256) @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("sat drained", out_valid, 1'b0);
    check("sat err_count", err_count, 8'hFF);

    // Clear coinciding with an errored output transfer.
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("clr out_valid", out_valid, 1'b1);
    check("clr out_err", out_err, 4'b1111);
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    check("clr priority", err_count, 8'h00);

    // Randomised traffic on the 1- and 6-digit instances.
    for (int c = 0; c < 400; c++) begin
      if (c < 380) begin
        a_in_valid = ($urandom_range(0, 3) != 0); a_in_data = 4'($urandom());
        a_in_src = 2'($urandom()); a_in_dst = 2'($urandom());
        a_out_ready = ($urandom_range(0, 3) != 0);
        b_in_valid = ($urandom_range(0, 3) != 0); b_in_data = 24'($urandom());
        b_in_src = 2'($urandom()); b_in_dst = 2'($urandom());
        b_out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_out_ready = 1'b1;
      end
      @(negedge clk);
      if (a_out_valid && a_out_ready) begin
        check("d1 word expected", 64'(qa.size() != 0), 1);
        if (qa.size() != 0) begin
          e = qa.pop_front();
          check("d1 data", a_out_data, e.d);
          check("d1 err", a_out_err, e.e);
        end
      end
      if (b_out_valid && b_out_ready) begin
        check("d6 word expected", 64'(qb.size() != 0), 1);
        if (qb.size() != 0) begin
          e = qb.pop_front();
          check("d6 data", b_out_data, e.d);
          check("d6 err", b_out_err, e.e);
        end
      end
      a_acc = a_in_valid && a_in_ready;
      b_acc = b_in_valid && b_in_ready;
      if (a_acc) qa.push_back(ref_word(1, {20'd0, a_in_data}, a_in_src, a_in_dst));
      if (b_acc) qb.push_back(ref_word(6, b_in_data, b_in_src, b_in_dst));
      @(posedge clk); #1;
    end
    check("d1 all words out", qa.size(), 0);
    check("d6 all words out", qb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
